// File: rtl/syndrome_ctrl_pkg.sv
// Shared types and constants for the syndrome sequencer: FSM state encoding
// and the per-syndrome cycle budget (engine restart plus E+1 cycles of settling).
package syndrome_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      KICK = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEF_ECC_BITS = 171;

   // One KICK cycle plus E+1 RUN cycles (counter values 0..E)
   localparam int SYN_CYCLES = DEF_ECC_BITS + 2;

   function automatic int syn_cycles(input int ecc_bits);
      return ecc_bits + 2;
   endfunction

endpackage

// File: rtl/syn_regfile.sv
// Syndrome result store: N slots of M bits, one write port, whole array
// visible on a packed read-out bus (slot j at bits [j*M +: M]).
module syn_regfile #(
   parameter int PARAM_M           = 4,
   parameter int PARAM_NUM_SYN     = 4,
   parameter int PARAM_LOG_NUM_SYN = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               we,
   input  logic [PARAM_LOG_NUM_SYN-1:0]       widx,
   input  logic [PARAM_M-1:0]                 wdata,
   output logic [PARAM_NUM_SYN*PARAM_M-1:0]   rdata
);

   logic [PARAM_M-1:0] mem [PARAM_NUM_SYN];

   // NOTE: this storage is reset on purpose -- the array is tiny and reset must
   // wipe any partial result so an aborted run never shows stale syndromes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PARAM_NUM_SYN; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   for (genvar g = 0; g < PARAM_NUM_SYN; g++) begin : g_rd
      assign rdata[g*PARAM_M +: PARAM_M] = mem[g];
   end

endmodule

// File: rtl/syndrome_ctrl.sv
// Sequencer around an external syndrome engine: restarts the engine once per
// syndrome index, waits for it to settle and collects the N results.
module syndrome_ctrl
   import syndrome_ctrl_pkg::*;
#(
   parameter int PARAM_M            = 4,
   parameter int PARAM_ECC_BITS     = DEF_ECC_BITS,
   parameter int PARAM_LOG_ECC_BITS = 8,
   parameter int PARAM_NUM_SYN      = 4,
   parameter int PARAM_LOG_NUM_SYN  = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [PARAM_ECC_BITS-1:0]              in_cw,
   output logic                                   busy,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [PARAM_NUM_SYN*PARAM_M-1:0]       out_syn,
   output logic                                   eng_rst,
   output logic [PARAM_LOG_NUM_SYN-1:0]           eng_sel,
   output logic [PARAM_ECC_BITS-1:0]              eng_cw,
   input  logic [PARAM_M-1:0]                     eng_syn
);

   localparam int CYC_PER_SYN = syn_cycles(PARAM_ECC_BITS);

   localparam logic [PARAM_LOG_ECC_BITS-1:0] CNT_LAST =
      PARAM_LOG_ECC_BITS'(CYC_PER_SYN - 2);
   localparam logic [PARAM_LOG_NUM_SYN-1:0]  IDX_LAST =
      PARAM_LOG_NUM_SYN'(PARAM_NUM_SYN - 1);

   state_t                          state;
   state_t                          state_nxt;
   logic [PARAM_LOG_NUM_SYN-1:0]    idx;
   logic [PARAM_LOG_ECC_BITS-1:0]   cnt;
   logic [PARAM_ECC_BITS-1:0]       cw_q;
   logic                            cnt_last;
   logic                            idx_last;
   logic                            slot_we;

   assign cnt_last = (cnt == CNT_LAST);
   assign idx_last = (idx == IDX_LAST);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
         cw_q  <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (start) begin
                  cw_q <= in_cw;
                  idx  <= '0;
               end
            end
            KICK: cnt <= '0;
            RUN: begin
               // Counter parks at E; the slot write and index step share this edge
               if (!cnt_last) begin
                  cnt <= cnt + PARAM_LOG_ECC_BITS'(1);
               end else if (!idx_last) begin
                  idx <= idx + PARAM_LOG_NUM_SYN'(1);
               end
            end
            DONE: ;
            default: ;
         endcase
      end
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      slot_we   = 1'b0;
      unique case (state)
         IDLE: if (start) state_nxt = KICK;
         KICK: state_nxt = RUN;
         RUN: begin
            if (cnt_last) begin
               slot_we   = 1'b1;
               state_nxt = idx_last ? DONE : KICK;
            end
         end
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign eng_rst   = rst | (state == KICK);
   assign eng_sel   = idx;
   assign eng_cw    = cw_q;

   syn_regfile #(
      .PARAM_M           (PARAM_M),
      .PARAM_NUM_SYN     (PARAM_NUM_SYN),
      .PARAM_LOG_NUM_SYN (PARAM_LOG_NUM_SYN)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (slot_we),
      .widx  (idx),
      .wdata (eng_syn),
      .rdata (out_syn)
   );

endmodule

// File: tb/tb_syndrome_ctrl.sv
// Directed bench for syndrome_ctrl with a behavioural GF(16) Horner engine
// (x^4+x+1) evaluating the codeword at alpha^(eng_sel+1).
module tb_syndrome_ctrl;
   import syndrome_ctrl_pkg::*;

   localparam int M  = 4;
   localparam int E  = 171;
   localparam int LE = 8;
   localparam int N  = 4;
   localparam int LN = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [E-1:0]    in_cw;
   logic            busy;
   logic            out_valid;
   logic            out_ready;
   logic [N*M-1:0]  out_syn;
   logic            eng_rst;
   logic [LN-1:0]   eng_sel;
   logic [E-1:0]    eng_cw;
   logic [M-1:0]    eng_syn;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int t0       = 0;
   int kick_n   = 0;
   int kick_at [8];

   syndrome_ctrl #(
      .PARAM_M            (M),
      .PARAM_ECC_BITS     (E),
      .PARAM_LOG_ECC_BITS (LE),
      .PARAM_NUM_SYN      (N),
      .PARAM_LOG_NUM_SYN  (LN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_cw     (in_cw),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_syn   (out_syn),
      .eng_rst   (eng_rst),
      .eng_sel   (eng_sel),
      .eng_cw    (eng_cw),
      .eng_syn   (eng_syn)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural engine: MSB-first Horner evaluation, one bit per cycle
   function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p;
      logic [3:0] aa;
      p  = 4'h0;
      aa = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [3:0] alpha_pow(input logic [LN-1:0] sel);
      case (sel)
         2'd0:    return 4'h2;
         2'd1:    return 4'h4;
         2'd2:    return 4'h8;
         default: return 4'h3;
      endcase
   endfunction

   logic [3:0] eng_acc;
   int         eng_n;
   always @(posedge clk) begin
      if (eng_rst) begin
         eng_acc <= 4'h0;
         eng_n   <= 0;
      end else if (eng_n < E) begin
         eng_acc <= gf_mul(eng_acc, alpha_pow(eng_sel)) ^ {3'b000, eng_cw[E-1-eng_n]};
         eng_n   <= eng_n + 1;
      end
   end
   assign eng_syn = eng_acc;

   always @(negedge clk) begin
      if (eng_rst && !rst) begin
         if (kick_n < 8) kick_at[kick_n] <= cyc;
         kick_n <= kick_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; start is sampled on the following rising edge (T0)
   task automatic start_op(input logic [E-1:0] cw);
      in_cw  = cw;
      start  = 1'b1;
      kick_n = 0;
      @(negedge clk);
      start = 1'b0;
      t0    = cyc;
      in_cw = '1;
   endtask

   task automatic wait_valid(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
      check({tag, "_latency"}, cyc - t0, 32'd692);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic release_and_check(input string tag, input logic [15:0] exp_syn);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_idle_busy"},  busy,      32'd0);
      check({tag, "_idle_valid"}, out_valid, 32'd0);
      check({tag, "_retain"},     out_syn,   exp_syn);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      in_cw     = '0;
      repeat (3) @(negedge clk);

      check("rst_busy",    busy,      32'd0);
      check("rst_valid",   out_valid, 32'd0);
      check("rst_syn",     out_syn,   32'd0);
      check("rst_eng_rst", eng_rst,   32'd1);
      check("rst_eng_cw",  |eng_cw,   32'd0);

      // Start is offered while in reset and must not be remembered
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      check("post_rst_eng_rst", eng_rst, 32'd0);
      check("post_rst_busy",    busy,    32'd0);

      // All-zero codeword
      start_op('0);
      check("t1_busy",    busy,    32'd1);
      check("t1_eng_rst", eng_rst, 32'd1);
      wait_valid("t1");
      check("t1_syn", out_syn, 32'h0000);
      release_and_check("t1", 16'h0000);

      // Bit 0 only: every syndrome is 1; start re-pulsed mid-run and in DONE
      start_op(E'(1));
      check("t2_eng_cw", eng_cw[31:0], 32'h1);
      wait_until(t0 + 100);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t2_cw_hold", eng_cw[31:0], 32'h1);
      wait_valid("t2");
      check("t2_syn",    out_syn, 32'h1111);
      check("t2_kicks",  kick_n,  32'd4);
      check("t2_kick0",  kick_at[0] - t0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t2_kick_gap%0d", i), kick_at[i+1] - kick_at[i], 32'd173);
      end
      for (int i = 0; i < 20; i++) begin
         if (i == 5) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check($sformatf("t2_stall_valid%0d", i), out_valid, 32'd1);
         check($sformatf("t2_stall_syn%0d", i),   out_syn,   32'h1111);
      end
      check("t2_kicks_after_done", kick_n, 32'd4);
      release_and_check("t2", 16'h1111);

      // Bit 1 only, started in the cycle right after returning to IDLE
      start_op(E'(2));
      check("t3_accept", busy, 32'd1);
      wait_valid("t3");
      check("t3_syn", out_syn, 32'h3842);
      release_and_check("t3", 16'h3842);

      // Bits 0 and 1; reset lands in the RUN phase of syndrome 2
      start_op(E'(3));
      wait_until(t0 + 2 * 173 + 60);
      check("t4_pre_rst_sel", eng_sel, 32'd2);
      rst = 1'b1;
      #1;
      check("t4_rst_eng_rst", eng_rst, 32'd1);
      @(negedge clk);
      check("t4_rst_busy",   busy,      32'd0);
      check("t4_rst_valid",  out_valid, 32'd0);
      check("t4_rst_syn",    out_syn,   32'd0);
      check("t4_rst_eng_cw", |eng_cw,   32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t4_post_busy",  busy,      32'd0);
      check("t4_post_valid", out_valid, 32'd0);

      start_op(E'(3));
      wait_valid("t5");
      check("t5_syn",   out_syn, 32'h2953);
      check("t5_kicks", kick_n,  32'd4);
      release_and_check("t5", 16'h2953);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
